// File: rtl/regfile_2r1w.sv
// 2-read / 1-write register file: r0 reads as zero, and a write is forwarded to the read ports in the same cycle.
// Optional macro REGFILE_DBG_PORT_EN adds a committed-state debug read port and an accepted-write counter.
module regfile_2r1w #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
`ifdef REGFILE_DBG_PORT_EN
    ,
    input  logic [ADDR_W-1:0] dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [31:0]       dbg_wr_count
`endif
);

    logic [DATA_W-1:0] mem [NUM_REGS];
    logic              wr_accept;

    assign wr_accept = we && (waddr != '0);

    // Entry 0 is cleared by reset and never written, so it stays zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_accept) begin
            mem[waddr] <= wdata;
        end
    end

    logic [1:0]        re_v;
    logic [ADDR_W-1:0] raddr_v [2];
    logic [DATA_W-1:0] rdata_v [2];

    assign re_v[0]    = re1;
    assign re_v[1]    = re2;
    assign raddr_v[0] = raddr1;
    assign raddr_v[1] = raddr2;
    assign rdata1     = rdata_v[0];
    assign rdata2     = rdata_v[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            always_comb begin
                rdata_v[gi] = '0;
                if (rst || (raddr_v[gi] == '0) || !re_v[gi]) begin
                    rdata_v[gi] = '0;
                end else if (we && (raddr_v[gi] == waddr)) begin
                    rdata_v[gi] = wdata;
                end else begin
                    rdata_v[gi] = mem[raddr_v[gi]];
                end
            end
        end
    endgenerate

`ifdef REGFILE_DBG_PORT_EN
    logic [31:0] wr_count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_count_reg <= '0;
        end else if (wr_accept) begin
            wr_count_reg <= wr_count_reg + 32'd1;
        end
    end

    // Debug view shows committed state only: no write bypass.
    assign dbg_rdata    = rst ? '0 : mem[dbg_raddr];
    assign dbg_wr_count = wr_count_reg;
`endif

endmodule

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench for regfile_2r1w: directed vector table, reset corner cases and a random run against an array model.
// Define REGFILE_DBG_PORT_EN to also exercise the debug port.
module tb_regfile_2r1w;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
`ifdef REGFILE_DBG_PORT_EN
    logic [4:0]  dbg_raddr;
    logic [31:0] dbg_rdata;
    logic [31:0] dbg_wr_count;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] model [32];

    regfile_2r1w #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2)
`ifdef REGFILE_DBG_PORT_EN
        , .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata), .dbg_wr_count(dbg_wr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        re1;
        logic [4:0]  raddr1;
        logic        re2;
        logic [4:0]  raddr2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h required %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic r1, input logic [4:0] a1, input logic r2, input logic [4:0] a2);
        we = w; waddr = wa; wdata = wd;
        re1 = r1; raddr1 = a1; re2 = r2; raddr2 = a2;
    endtask

    // Reference read: what decode should see given the current inputs and committed model state.
    function automatic logic [31:0] model_read(input logic r, input logic [4:0] a);
        if (rst || a == 5'd0 || !r) return 32'h0;
        if (we && waddr == a) return wdata;
        return model[a];
    endfunction

    // Applied just before the rising edge that commits the current inputs.
    task automatic model_commit();
        if (!rst && we && waddr != 5'd0) model[waddr] = wdata;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        vecs[0] = '{1'b1, 5'd5,  32'h1234ABCD, 1'b0, 5'd5, 1'b0, 5'd5, 32'h0,        32'h0};
        vecs[1] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5, 1'b0, 5'd5, 32'h1234ABCD, 32'h0};
        vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0, 1'b1, 5'd0, 32'h0,        32'h0};
        vecs[3] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 1'b1, 5'd0, 32'h0,        32'h0};
        vecs[4] = '{1'b1, 5'd7,  32'h11,       1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        32'h0};
        vecs[5] = '{1'b1, 5'd7,  32'h22,       1'b1, 5'd7, 1'b1, 5'd7, 32'h22,       32'h22};
        vecs[6] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7, 1'b1, 5'd7, 32'h22,       32'h22};
        vecs[7] = '{1'b1, 5'd5,  32'hDEAD0001, 1'b1, 5'd7, 1'b1, 5'd5, 32'h22,       32'hDEAD0001};
        vecs[8] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd5, 1'b1, 5'd5, 32'h0,        32'hDEAD0001};

        // Reset held: a matching write/read pair must still read zero and the write must be dropped.
        rst = 1'b1;
        drive(1'b1, 5'd9, 32'h5, 1'b1, 5'd9, 1'b1, 5'd9);
`ifdef REGFILE_DBG_PORT_EN
        dbg_raddr = 5'd9;
`endif
        #1;
        check("rst_rd1", rdata1, 32'h0);
        check("rst_rd2", rdata2, 32'h0);

        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b1, 5'(31 - i));
            #1;
            check($sformatf("post_rst_rd1_r%0d", i), rdata1, 32'h0);
            check($sformatf("post_rst_rd2_r%0d", 31 - i), rdata2, 32'h0);
        end

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].re1, vecs[i].raddr1,
                  vecs[i].re2, vecs[i].raddr2);
            #1;
            check($sformatf("vec%0d_rd1", i), rdata1, vecs[i].exp1);
            check($sformatf("vec%0d_rd2", i), rdata2, vecs[i].exp2);
            model_commit();
        end

        // Async reset mid-cycle with no clock edge in between.
        @(negedge clk);
        drive(1'b1, 5'd31, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0, 5'd0);
        model_commit();
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 1'b1, 5'd31);
        #1;
        check("r31_before_rst", rdata1, 32'hA5A5A5A5);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_rd1", rdata1, 32'h0);
        check("async_rst_rd2", rdata2, 32'h0);
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        drive(1'b1, 5'd3, 32'h77, 1'b1, 5'd31, 1'b1, 5'd31);
        @(negedge clk);
        rst = 1'b0;
        // First write after release lands on the first edge with rst low.
        drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd31, 1'b1, 5'd3);
        #1;
        check("r31_after_rst", rdata1, 32'h0);
        check("r3_write_in_rst", rdata2, 32'h0);
        model_commit();
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0, 5'd4);
        #1;
        check("first_write_after_rst", rdata1, 32'h44);
        check("re2_off", rdata2, 32'h0);

        // Random traffic on a narrow address range so bypass collisions are common.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] wa, a1, a2;
            logic [31:0] e1, e2;
            @(negedge clk);
            wa = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            a1 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            a2 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            drive(1'($urandom), wa, $urandom, ($urandom_range(0, 3) != 0), a1,
                  ($urandom_range(0, 3) != 0), a2);
            #1;
            e1 = model_read(re1, raddr1);
            e2 = model_read(re2, raddr2);
            if (rdata1 !== e1 || rdata2 !== e2)
                $display("cycle %0d we=%0b wa=%0d a1=%0d a2=%0d", n, we, waddr, raddr1, raddr2);
            check("rand_rd1", rdata1, e1);
            check("rand_rd2", rdata2, e2);
            model_commit();
        end

`ifdef REGFILE_DBG_PORT_EN
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        check("dbg_cnt_rst", dbg_wr_count, 32'd0);
        drive(1'b1, 5'd1, 32'h101, 1'b0, 5'd0, 1'b0, 5'd0);
        @(negedge clk);
        drive(1'b1, 5'd0, 32'h999, 1'b0, 5'd0, 1'b0, 5'd0);
        @(negedge clk);
        drive(1'b1, 5'd2, 32'h202, 1'b0, 5'd0, 1'b0, 5'd0);
        @(negedge clk);
        drive(1'b1, 5'd2, 32'h303, 1'b1, 5'd2, 1'b0, 5'd0);
        dbg_raddr = 5'd2;
        #1;
        check("dbg_cnt_3wr", dbg_wr_count, 32'd2);
        check("dbg_no_bypass", dbg_rdata, 32'h202);
        check("dbg_bypass_rd1", rdata1, 32'h303);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
        #1;
        check("dbg_after_edge", dbg_rdata, 32'h303);
        check("dbg_cnt_4wr", dbg_wr_count, 32'd3);
        dbg_raddr = 5'd0;
        #1;
        check("dbg_r0", dbg_rdata, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
